// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, drives the I-cache request and halts on HLT.
module fetch_stage #(
    parameter logic [15:0] NOP_INSTR  = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF,
    parameter logic [15:0] RESET_PC   = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        imem_ready,
    input  logic [15:0] imem_data,
    output logic [15:0] imem_addr,
    output logic        imem_en,
    output logic [15:0] instr_FD,
    output logic [15:0] pcPlus2_FD,
    output logic        valid_FD,
    output logic        halted
);

    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] HALTED = 1'b1;

    logic [0:0]  state;
    logic [0:0]  stateNext;
    logic [15:0] pcReg;
    logic [15:0] pcNext;
    logic [15:0] pcInc;
    logic [15:0] instrNext;
    logic [15:0] pc2Next;
    logic        validNext;
    logic        isHlt;

    assign pcInc = pcReg + 16'd2;
    assign isHlt = (imem_data[15:12] == HLT_OPCODE);

    // Redirect beats stall; a halted front end only drains IF/ID.
    always_comb begin
        stateNext = state;
        pcNext    = pcReg;
        instrNext = instr_FD;
        pc2Next   = pcPlus2_FD;
        validNext = valid_FD;
        if (branch_taken) begin
            stateNext = RUN;
            pcNext    = {branch_target[15:1], 1'b0};
            instrNext = NOP_INSTR;
            validNext = 1'b0;
        end else if (!stall) begin
            if (state == HALTED || !imem_ready) begin
                instrNext = NOP_INSTR;
                validNext = 1'b0;
            end else begin
                instrNext = imem_data;
                pc2Next   = pcInc;
                validNext = 1'b1;
                if (isHlt) begin
                    stateNext = HALTED;
                end else begin
                    pcNext = pcInc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            pcReg      <= RESET_PC;
            instr_FD   <= NOP_INSTR;
            pcPlus2_FD <= 16'h0000;
            valid_FD   <= 1'b0;
        end else begin
            state      <= stateNext;
            pcReg      <= pcNext;
            instr_FD   <= instrNext;
            pcPlus2_FD <= pc2Next;
            valid_FD   <= validNext;
        end
    end

    assign imem_addr = pcReg;
    assign imem_en   = (state == RUN) && !rst;
    assign halted    = (state == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage.
// Table of per-edge stimulus with hand-computed IF/ID state.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        imem_ready;
    logic [15:0] imem_data;
    logic [15:0] imem_addr;
    logic        imem_en;
    logic [15:0] instr_FD;
    logic [15:0] pcPlus2_FD;
    logic        valid_FD;
    logic        halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_ready   (imem_ready),
        .imem_data    (imem_data),
        .imem_addr    (imem_addr),
        .imem_en      (imem_en),
        .instr_FD     (instr_FD),
        .pcPlus2_FD   (pcPlus2_FD),
        .valid_FD     (valid_FD),
        .halted       (halted)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic        rdy;
        logic [15:0] data;
        logic [15:0] eAddr;
        logic        eEn;
        logic [15:0] eInstr;
        logic [15:0] ePc2;
        logic        eValid;
        logic        eHalt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx,
                         input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic checkAll(input int idx, input vec_t v);
        check("imem_addr", idx, imem_addr, v.eAddr);
        check("imem_en", idx, {15'd0, imem_en}, {15'd0, v.eEn});
        check("instr_FD", idx, instr_FD, v.eInstr);
        check("pcPlus2_FD", idx, pcPlus2_FD, v.ePc2);
        check("valid_FD", idx, {15'd0, valid_FD}, {15'd0, v.eValid});
        check("halted", idx, {15'd0, halted}, {15'd0, v.eHalt});
    endtask

    initial begin
        // rst stl br  tgt      rdy data      addr     en instr     pc2      v  h
        vecs.push_back('{1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0});
        vecs.push_back('{0, 0, 0, 16'h0000, 1, 16'h1111, 16'h0002, 1, 16'h1111, 16'h0002, 1, 0});
        vecs.push_back('{0, 0, 0, 16'h0000, 1, 16'h2222, 16'h0004, 1, 16'h2222, 16'h0004, 1, 0});
        vecs.push_back('{0, 1, 0, 16'h0000, 1, 16'h3333, 16'h0004, 1, 16'h2222, 16'h0004, 1, 0});
        vecs.push_back('{0, 1, 0, 16'h0000, 1, 16'h3333, 16'h0004, 1, 16'h2222, 16'h0004, 1, 0});
        vecs.push_back('{0, 0, 0, 16'h0000, 1, 16'h3333, 16'h0006, 1, 16'h3333, 16'h0006, 1, 0});
        vecs.push_back('{0, 1, 1, 16'h0041, 1, 16'h9999, 16'h0040, 1, 16'h0000, 16'h0006, 0, 0});
        vecs.push_back('{0, 0, 1, 16'h0010, 1, 16'h9999, 16'h0010, 1, 16'h0000, 16'h0006, 0, 0});
        vecs.push_back('{0, 0, 0, 16'h0000, 0, 16'h8888, 16'h0010, 1, 16'h0000, 16'h0006, 0, 0});
        vecs.push_back('{0, 0, 0, 16'h0000, 0, 16'h8888, 16'h0010, 1, 16'h0000, 16'h0006, 0, 0});
        vecs.push_back('{0, 0, 0, 16'h0000, 0, 16'h8888, 16'h0010, 1, 16'h0000, 16'h0006, 0, 0});
        vecs.push_back('{0, 0, 0, 16'h0000, 1, 16'h4444, 16'h0012, 1, 16'h4444, 16'h0012, 1, 0});
        vecs.push_back('{0, 0, 1, 16'h0020, 1, 16'h9999, 16'h0020, 1, 16'h0000, 16'h0012, 0, 0});
        vecs.push_back('{0, 0, 0, 16'h0000, 1, 16'hF000, 16'h0020, 0, 16'hF000, 16'h0022, 1, 1});
        vecs.push_back('{0, 1, 0, 16'h0000, 1, 16'h5555, 16'h0020, 0, 16'hF000, 16'h0022, 1, 1});
        vecs.push_back('{0, 0, 0, 16'h0000, 1, 16'h5555, 16'h0020, 0, 16'h0000, 16'h0022, 0, 1});
        vecs.push_back('{0, 0, 0, 16'h0000, 1, 16'h5555, 16'h0020, 0, 16'h0000, 16'h0022, 0, 1});
        vecs.push_back('{0, 0, 1, 16'h0100, 1, 16'h5555, 16'h0100, 1, 16'h0000, 16'h0022, 0, 0});
        vecs.push_back('{0, 0, 0, 16'h0000, 1, 16'h6666, 16'h0102, 1, 16'h6666, 16'h0102, 1, 0});
        vecs.push_back('{0, 0, 1, 16'hFFFE, 1, 16'h9999, 16'hFFFE, 1, 16'h0000, 16'h0102, 0, 0});
        vecs.push_back('{0, 0, 0, 16'h0000, 1, 16'h7777, 16'h0000, 1, 16'h7777, 16'h0000, 1, 0});
        vecs.push_back('{0, 0, 1, 16'h0030, 1, 16'h9999, 16'h0030, 1, 16'h0000, 16'h0000, 0, 0});
        vecs.push_back('{0, 0, 0, 16'h0000, 1, 16'hF123, 16'h0030, 0, 16'hF123, 16'h0032, 1, 1});
        vecs.push_back('{1, 0, 0, 16'h0000, 1, 16'h1234, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0});
        vecs.push_back('{0, 0, 0, 16'h0000, 0, 16'h1234, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0});
        vecs.push_back('{0, 0, 0, 16'h0000, 1, 16'h2345, 16'h0002, 1, 16'h2345, 16'h0002, 1, 0});
        vecs.push_back('{0, 0, 0, 16'h0000, 0, 16'h2345, 16'h0002, 1, 16'h0000, 16'h0002, 0, 0});
        vecs.push_back('{1, 0, 0, 16'h0000, 0, 16'h2345, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0});

        rst           = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        imem_ready    = 1'b0;
        imem_data     = 16'h0000;

        foreach (vecs[i]) begin
            rst           = vecs[i].rst;
            stall         = vecs[i].stall;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].tgt;
            imem_ready    = vecs[i].rdy;
            imem_data     = vecs[i].data;
            @(posedge clk);
            #1;
            checkAll(i, vecs[i]);
        end

        // Leave reset, then wiggle redirect/stall/ready mid-cycle:
        // no output may follow them combinationally.
        rst        = 1'b0;
        imem_ready = 1'b0;
        @(posedge clk);
        #1;
        check("en_after_rst", 100, {15'd0, imem_en}, 16'h0001);
        branch_taken  = 1'b1;
        branch_target = 16'h0200;
        stall         = 1'b1;
        imem_ready    = 1'b1;
        imem_data     = 16'hF000;
        #2;
        check("comb_addr", 101, imem_addr, 16'h0000);
        check("comb_en", 101, {15'd0, imem_en}, 16'h0001);
        check("comb_valid", 101, {15'd0, valid_FD}, 16'h0000);
        check("comb_halt", 101, {15'd0, halted}, 16'h0000);
        branch_taken = 1'b0;
        stall        = 1'b0;
        imem_ready   = 1'b0;

        // Halt, then a miss while halted still drains to a bubble.
        imem_ready = 1'b1;
        imem_data  = 16'hF0F0;
        @(posedge clk);
        #1;
        check("hlt_instr", 102, instr_FD, 16'hF0F0);
        check("hlt_addr", 102, imem_addr, 16'h0000);
        imem_ready = 1'b0;
        @(posedge clk);
        #1;
        check("hlt_drain_valid", 103, {15'd0, valid_FD}, 16'h0000);
        check("hlt_drain_instr", 103, instr_FD, 16'h0000);
        check("hlt_still", 103, {15'd0, halted}, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
